gb_fanout: RTL and testbench
============================

Name: gb_fanout

Overview:
- Parametrised ghostbus interposer. Splits one upstream ghostbus port across NCH child ports, each owning a contiguous power-of-two address window.
- Registers the forward path and the read-return path, so deep hierarchies close timing. Children keep their existing ghostbus ports unchanged.
- Adds behaviour a plain interposer lacks: out-of-window detection, a fixed and known read latency, and a saturating miss counter for bring-up debug.

Parameters:
- AW, 24, upstream address width.
- DW, 32, data width.
- NCH, 4, number of child channels (1..16).
- CH_AW, 16, child window address width; window size is 2^CH_AW words. Must satisfy CH_AW + clog2(NCH) <= AW.
- BASE, 0, upstream address of channel 0. Must be aligned to 2^CH_AW.
- RD_LAT, 1, child read latency in cycles, from child rstb to valid child din (0..7).
- MISS_VAL, 32'hDEADBEEF, read data returned for out-of-window reads.

Ports:
- GBPORT_clk, in, 1: bus clock. Single clock domain.
- GBPORT_rst_n, in, 1: asynchronous active-low reset.
- GBPORT_addr, in, AW: upstream address.
- GBPORT_dout, in, DW: upstream write data.
- GBPORT_din, out, DW: upstream read data.
- GBPORT_we, in, 1: write enable.
- GBPORT_wstb, in, 1: write strobe.
- GBPORT_rstb, in, 1: read strobe.
- ch_addr, out, NCH*CH_AW: per-channel local address; channel i occupies slice i.
- ch_dout, out, NCH*DW: per-channel write data.
- ch_din, in, NCH*DW: per-channel read data.
- ch_we, out, NCH: per-channel write enable.
- ch_wstb, out, NCH: per-channel write strobe.
- ch_rstb, out, NCH: per-channel read strobe.
- miss_cnt, out, 16: saturating count of out-of-window accesses.

Behaviour:
- Clock and reset: one clock, GBPORT_clk. Reset GBPORT_rst_n is asynchronous, active-low.
- Reset values: every output and every internal register is 0. This includes GBPORT_din, all ch_* outputs, miss_cnt and the read-tracking pipeline.
- Decode: off = GBPORT_addr - BASE.
  - hit when GBPORT_addr >= BASE and (off >> CH_AW) < NCH.
  - sel = off >> CH_AW.
  - local address = off[CH_AW-1:0].
- Forward stage (1 cycle): on each clock edge every channel's ch_addr and ch_dout take the local address and GBPORT_dout, whether or not that channel is selected. On a hit, ch_we, ch_wstb and ch_rstb of channel sel take the upstream values one cycle late; all other channels' strobes are 0. Strobes are single-cycle pulses mirroring upstream.
- Miss handling: a miss asserts no channel strobe.
  - A write miss is dropped.
  - A read miss is answered with MISS_VAL.
  - Each wstb or rstb cycle that misses increments miss_cnt, saturating at 16'hFFFF.
  - A strobe with no address hit and no strobe asserted counts nothing.
- Read tracking: a shift pipeline of depth RD_LAT+1 carries {valid, hit, sel}, entered on each upstream rstb. It advances every cycle and needs no handshake. Back-to-back reads on consecutive cycles are supported.
- Return stage: when the pipeline tail is valid, GBPORT_din is registered with either ch_din[sel] (hit) or MISS_VAL (miss).
  - Total latency from upstream rstb to valid GBPORT_din is RD_LAT+2 cycles.
  - Software and the parent decoder rely on this figure; it must be exact.
- Hold: GBPORT_din holds its last returned value until the next return. It is never cleared between reads.
- Simultaneous wstb and rstb in one cycle: both are forwarded to the same channel in the same cycle. The miss count increments by 1, not 2.
- Reset mid-read: in-flight reads are discarded and no stale return appears after reset release.
- Width rules: the subtraction is AW bits unsigned. A borrow (GBPORT_addr < BASE) is a miss.

Decomposition:
- Shared package: a clog2 function, the miss-counter width constant (16), and a packed struct {valid, hit, sel[3:0]} for read-tracking entries.
- One natural sub-module, gb_fanout_decode: the combinational hit/sel/local-address decode. It is reused by the next-level address checker.
- The forward registers, return mux/registers and miss counter stay in gb_fanout.

Test Plan:
- NCH=4, CH_AW=16, BASE=24'h100000, RD_LAT=1. Write 32'h12345678 to 24'h120004 -> next cycle ch_wstb=4'b0100, ch_addr slice2=16'h0004, ch_dout slice2=32'h12345678; no other strobes.
- Child 3 drives ch_din=32'hCAFE0003. Read 24'h13FFFC -> ch_rstb[3] one cycle later; GBPORT_din=32'hCAFE0003 exactly 3 cycles after upstream rstb; value holds afterwards.
- Read 24'h140000 (above window) and 24'h0FFFFF (below BASE) -> no ch_rstb; GBPORT_din=32'hDEADBEEF at +3 for each read; miss_cnt=2.
- Back-to-back reads on 4 consecutive cycles to channels 0,1,2,3, each child returning a distinct value -> four consecutive GBPORT_din values in the same order, starting at +3.
- Issue a read, assert GBPORT_rst_n=0 one cycle later, release -> all outputs 0 during reset; GBPORT_din stays 0 with no late return.
- Force 65540 write misses -> miss_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/gb_fanout_pkg.sv
// Shared types and helpers for the gb_fanout interposer and its address decoder.
// Also used by the next-level address checker.
package gb_fanout_pkg;

  localparam int MISS_CNT_W = 16;

  // One entry of the read-tracking pipeline.
  typedef struct packed {
    logic       valid;
    logic       hit;
    logic [3:0] sel;
  } rd_track_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gb_fanout_if.sv
// Upstream ghostbus port bundle.
// The parent decoder is the master; the interposer is the slave.
interface gb_fanout_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic [DW-1:0] din;
  logic          we;
  logic          wstb;
  logic          rstb;

  modport master (output addr, dout, we, wstb, rstb, input din);
  modport slave  (input addr, dout, we, wstb, rstb, output din);
endinterface

// File: rtl/gb_fanout_decode.sv
// Combinational window decode: maps an upstream address to hit / channel / local offset.
// An address below BASE borrows and is always a miss.
module gb_fanout_decode
  import gb_fanout_pkg::*;
#(
  parameter int            AW    = 24,
  parameter int            NCH   = 4,
  parameter int            CH_AW = 16,
  parameter logic [AW-1:0] BASE  = '0
) (
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [3:0]       sel,
  output logic [CH_AW-1:0] local_addr
);

  if (CH_AW + clog2(NCH) > AW) begin : g_bad_geometry
    $error("gb_fanout_decode: CH_AW + clog2(NCH) exceeds AW");
  end

  logic [AW-1:0] off;
  logic [AW-1:0] win;

  always_comb begin
    off        = addr - BASE;
    win        = off >> CH_AW;
    hit        = (addr >= BASE) && (win < AW'(NCH));
    sel        = 4'(win);
    local_addr = off[CH_AW-1:0];
  end

endmodule

// File: rtl/gb_fanout.sv
// Registered ghostbus fan-out: one upstream port split across NCH child windows,
// with a fixed RD_LAT+2 read latency and a saturating out-of-window counter.
module gb_fanout
  import gb_fanout_pkg::*;
#(
  parameter int            AW       = 24,
  parameter int            DW       = 32,
  parameter int            NCH      = 4,
  parameter int            CH_AW    = 16,
  parameter logic [AW-1:0] BASE     = '0,
  parameter int            RD_LAT   = 1,
  parameter logic [DW-1:0] MISS_VAL = 32'hDEADBEEF
) (
  input  logic                  GBPORT_clk,
  input  logic                  GBPORT_rst_n,
  gb_fanout_if.slave            gbport,
  output logic [NCH*CH_AW-1:0]  ch_addr,
  output logic [NCH*DW-1:0]     ch_dout,
  input  logic [NCH*DW-1:0]     ch_din,
  output logic [NCH-1:0]        ch_we,
  output logic [NCH-1:0]        ch_wstb,
  output logic [NCH-1:0]        ch_rstb,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  logic             hit;
  logic [3:0]       sel;
  logic [CH_AW-1:0] local_addr;

  gb_fanout_decode #(
    .AW   (AW),
    .NCH  (NCH),
    .CH_AW(CH_AW),
    .BASE (BASE)
  ) u_decode (
    .addr      (gbport.addr),
    .hit       (hit),
    .sel       (sel),
    .local_addr(local_addr)
  );

  logic [NCH-1:0] chan_sel;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan_sel
    assign chan_sel[gi] = hit && (sel == 4'(gi));
  end

  logic [NCH*CH_AW-1:0]  ch_addr_reg;
  logic [NCH*DW-1:0]     ch_dout_reg;
  logic [NCH-1:0]        ch_we_reg;
  logic [NCH-1:0]        ch_wstb_reg;
  logic [NCH-1:0]        ch_rstb_reg;
  logic [MISS_CNT_W-1:0] miss_cnt_reg;
  logic [DW-1:0]         din_reg;
  rd_track_t             rd_pipe_reg [RD_LAT+1];

  rd_track_t rd_entry;
  rd_track_t rd_tail;
  logic      miss_evt;
  logic [DW-1:0] rd_mux;

  always_comb begin
    rd_entry.valid = gbport.rstb;
    rd_entry.hit   = gbport.rstb && hit;
    rd_entry.sel   = (gbport.rstb && hit) ? sel : 4'd0;
    // A combined wstb+rstb miss is one event, not two.
    miss_evt       = (gbport.wstb || gbport.rstb) && !hit;
    rd_tail        = rd_pipe_reg[RD_LAT];
    rd_mux         = MISS_VAL;
    if (rd_tail.hit) begin
      for (int i = 0; i < NCH; i++) begin
        if (rd_tail.sel == 4'(i)) rd_mux = ch_din[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge GBPORT_clk or negedge GBPORT_rst_n) begin
    if (!GBPORT_rst_n) begin
      ch_addr_reg  <= '0;
      ch_dout_reg  <= '0;
      ch_we_reg    <= '0;
      ch_wstb_reg  <= '0;
      ch_rstb_reg  <= '0;
      miss_cnt_reg <= '0;
      din_reg      <= '0;
      for (int i = 0; i <= RD_LAT; i++) rd_pipe_reg[i] <= '0;
    end else begin
      // Address and data fan out to every child; only strobes are steered.
      ch_addr_reg <= {NCH{local_addr}};
      ch_dout_reg <= {NCH{gbport.dout}};
      ch_we_reg   <= gbport.we   ? chan_sel : '0;
      ch_wstb_reg <= gbport.wstb ? chan_sel : '0;
      ch_rstb_reg <= gbport.rstb ? chan_sel : '0;

      if (miss_evt && (miss_cnt_reg != '1)) miss_cnt_reg <= miss_cnt_reg + 1'b1;

      rd_pipe_reg[0] <= rd_entry;
      for (int i = 1; i <= RD_LAT; i++) rd_pipe_reg[i] <= rd_pipe_reg[i-1];

      if (rd_tail.valid) din_reg <= rd_mux;
    end
  end

  assign ch_addr     = ch_addr_reg;
  assign ch_dout     = ch_dout_reg;
  assign ch_we       = ch_we_reg;
  assign ch_wstb     = ch_wstb_reg;
  assign ch_rstb     = ch_rstb_reg;
  assign miss_cnt    = miss_cnt_reg;
  assign gbport.din  = din_reg;

endmodule

// File: tb/tb_gb_fanout.sv
// Self-checking bench for gb_fanout: scoreboard of expected read returns keyed by due cycle,
// plus per-scenario checks of the forwarded strobes, reset behaviour and miss counter.
module tb_gb_fanout;
  import gb_fanout_pkg::*;

  localparam int            AW     = 24;
  localparam int            DW     = 32;
  localparam int            NCH    = 4;
  localparam int            CH_AW  = 16;
  localparam logic [23:0]   BASE   = 24'h100000;
  localparam int            RD_LAT = 1;
  localparam int            LAT    = RD_LAT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gb_fanout_if #(.AW(AW), .DW(DW)) gbport ();

  logic [NCH*CH_AW-1:0] ch_addr;
  logic [NCH*DW-1:0]    ch_dout;
  logic [NCH*DW-1:0]    ch_din;
  logic [NCH-1:0]       ch_we;
  logic [NCH-1:0]       ch_wstb;
  logic [NCH-1:0]       ch_rstb;
  logic [15:0]          miss_cnt;

  // Each child returns a fixed, channel-specific word.
  assign ch_din = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  gb_fanout #(
    .AW(AW), .DW(DW), .NCH(NCH), .CH_AW(CH_AW), .BASE(BASE),
    .RD_LAT(RD_LAT), .MISS_VAL(32'hDEADBEEF)
  ) dut (
    .GBPORT_clk  (clk),
    .GBPORT_rst_n(rst_n),
    .gbport      (gbport),
    .ch_addr     (ch_addr),
    .ch_dout     (ch_dout),
    .ch_din      (ch_din),
    .ch_we       (ch_we),
    .ch_wstb     (ch_wstb),
    .ch_rstb     (ch_rstb),
    .miss_cnt    (miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Read-return monitor: compares GBPORT_din on exactly the due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc == sb[0].due) begin
      n_checks++;
      if (gbport.din !== sb[0].val) begin
        $display("FAIL rd_return %s: din=%h expected %h at cycle %0d", sb[0].name, gbport.din, sb[0].val, cyc);
        n_fail++;
      end else begin
        $display("rd %s: din=%h at cycle %0d", sb[0].name, gbport.din, cyc);
      end
      void'(sb.pop_front());
    end
  end

  task automatic drive(input logic [23:0] a, input logic [31:0] d,
                       input logic we, input logic wstb, input logic rstb);
    gbport.addr = a;
    gbport.dout = d;
    gbport.we   = we;
    gbport.wstb = wstb;
    gbport.rstb = rstb;
  endtask

  task automatic idle();
    drive(24'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic [23:0] a, input logic [31:0] exp_val, input string name);
    exp_t e;
    drive(a, 32'h0, 1'b0, 1'b0, 1'b1);
    e.val  = exp_val;
    e.due  = cyc + LAT;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout: %0d returns outstanding, required 0", sb.size());
      n_fail++;
      sb.delete();
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (gbport.din !== 32'h0) begin $display("FAIL reset_din: got %h expected 0", gbport.din); n_fail++; end
    n_checks++;
    if ({ch_we, ch_wstb, ch_rstb} !== 12'h0) begin
      $display("FAIL reset_strobes: got %h expected 0", {ch_we, ch_wstb, ch_rstb}); n_fail++;
    end
    n_checks++;
    if (miss_cnt !== 16'h0) begin $display("FAIL reset_miss_cnt: got %h expected 0", miss_cnt); n_fail++; end
    n_checks++;
    if ({ch_addr, ch_dout} !== '0) begin $display("FAIL reset_addr_dout: got nonzero expected 0"); n_fail++; end
    rst_n = 1'b1;
    step();
    $display("reset: released at cycle %0d", cyc);
  endtask

  task automatic test_write();
    drive(24'h120004, 32'h12345678, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    $display("wr 120004 <= 12345678: ch_wstb=%b", ch_wstb);
    n_checks++;
    if (ch_wstb !== 4'b0100) begin $display("FAIL wr_wstb: got %b expected 0100", ch_wstb); n_fail++; end
    n_checks++;
    if (ch_we !== 4'b0100) begin $display("FAIL wr_we: got %b expected 0100", ch_we); n_fail++; end
    n_checks++;
    if (ch_rstb !== 4'b0000) begin $display("FAIL wr_rstb: got %b expected 0000", ch_rstb); n_fail++; end
    n_checks++;
    if (ch_addr[2*CH_AW +: CH_AW] !== 16'h0004) begin
      $display("FAIL wr_addr: got %h expected 0004", ch_addr[2*CH_AW +: CH_AW]); n_fail++;
    end
    n_checks++;
    if (ch_dout[2*DW +: DW] !== 32'h12345678) begin
      $display("FAIL wr_dout: got %h expected 12345678", ch_dout[2*DW +: DW]); n_fail++;
    end
    step();
    n_checks++;
    if (ch_wstb !== 4'b0000) begin $display("FAIL wr_pulse: got %b expected 0000", ch_wstb); n_fail++; end
  endtask

  task automatic test_read_hit();
    read(24'h13FFFC, 32'hCAFE0003, "hit_ch3");
    step();
    idle();
    n_checks++;
    if (ch_rstb !== 4'b1000) begin $display("FAIL rd_rstb: got %b expected 1000", ch_rstb); n_fail++; end
    n_checks++;
    if (ch_addr[3*CH_AW +: CH_AW] !== 16'hFFFC) begin
      $display("FAIL rd_addr: got %h expected FFFC", ch_addr[3*CH_AW +: CH_AW]); n_fail++;
    end
    step();
    // One cycle before the due cycle the old value must still be present.
    n_checks++;
    if (gbport.din !== 32'h0) begin $display("FAIL rd_early: got %h expected 0", gbport.din); n_fail++; end
    wait_drain();
    repeat (3) step();
    n_checks++;
    if (gbport.din !== 32'hCAFE0003) begin $display("FAIL rd_hold: got %h expected CAFE0003", gbport.din); n_fail++; end
  endtask

  task automatic test_read_miss();
    read(24'h140000, 32'hDEADBEEF, "miss_above");
    step();
    idle();
    n_checks++;
    if (ch_rstb !== 4'b0000) begin $display("FAIL miss_above_rstb: got %b expected 0000", ch_rstb); n_fail++; end
    step();
    n_checks++;
    if (gbport.din !== 32'hCAFE0003) begin $display("FAIL miss_early: got %h expected CAFE0003", gbport.din); n_fail++; end
    read(24'h0FFFFF, 32'hDEADBEEF, "miss_below");
    step();
    idle();
    n_checks++;
    if (ch_rstb !== 4'b0000) begin $display("FAIL miss_below_rstb: got %b expected 0000", ch_rstb); n_fail++; end
    wait_drain();
    n_checks++;
    if (miss_cnt !== 16'd2) begin $display("FAIL miss_cnt2: got %0d expected 2", miss_cnt); n_fail++; end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      a = BASE + (24'(i) << CH_AW) + 24'(i * 4);
      v = 32'hCAFE0000 + 32'(i);
      read(a, v, $sformatf("b2b_ch%0d", i));
      step();
      n_checks++;
      if (ch_rstb !== 4'(1 << i)) begin
        $display("FAIL b2b_rstb%0d: got %b expected %b", i, ch_rstb, 4'(1 << i)); n_fail++;
      end
    end
    idle();
    wait_drain();
  endtask

  task automatic test_simul();
    read(24'h110008, 32'hCAFE0001, "simul_hit");
    gbport.we   = 1'b1;
    gbport.wstb = 1'b1;
    gbport.dout = 32'h000055AA;
    step();
    idle();
    n_checks++;
    if ({ch_wstb, ch_rstb} !== 8'b0010_0010) begin
      $display("FAIL simul_hit_strobes: got %b_%b expected 0010_0010", ch_wstb, ch_rstb); n_fail++;
    end
    read(24'h000010, 32'hDEADBEEF, "simul_miss");
    gbport.we   = 1'b1;
    gbport.wstb = 1'b1;
    step();
    idle();
    n_checks++;
    if ({ch_wstb, ch_rstb} !== 8'h00) begin
      $display("FAIL simul_miss_strobes: got %b_%b expected 0000_0000", ch_wstb, ch_rstb); n_fail++;
    end
    n_checks++;
    if (miss_cnt !== 16'd3) begin $display("FAIL simul_miss_cnt: got %0d expected 3", miss_cnt); n_fail++; end
    wait_drain();
  endtask

  task automatic test_reset_mid_read();
    drive(24'h120000, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    $display("reset mid-read at cycle %0d", cyc);
    n_checks++;
    if (gbport.din !== 32'h0) begin $display("FAIL midrst_din: got %h expected 0", gbport.din); n_fail++; end
    n_checks++;
    if ({ch_we, ch_wstb, ch_rstb} !== 12'h0) begin
      $display("FAIL midrst_strobes: got %h expected 0", {ch_we, ch_wstb, ch_rstb}); n_fail++;
    end
    n_checks++;
    if (miss_cnt !== 16'h0) begin $display("FAIL midrst_miss_cnt: got %h expected 0", miss_cnt); n_fail++; end
    n_checks++;
    if ({ch_addr, ch_dout} !== '0) begin $display("FAIL midrst_addr_dout: got nonzero expected 0"); n_fail++; end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (gbport.din !== 32'h0) begin
        $display("FAIL midrst_stale%0d: got %h expected 0", k, gbport.din); n_fail++;
      end
    end
  endtask

  task automatic test_saturation();
    drive(24'h000000, 32'h0, 1'b1, 1'b1, 1'b0);
    repeat (65534) step();
    $display("sat: miss_cnt=%h after 65534 write misses", miss_cnt);
    n_checks++;
    if (miss_cnt !== 16'hFFFE) begin $display("FAIL sat_pre: got %h expected FFFE", miss_cnt); n_fail++; end
    n_checks++;
    if (ch_wstb !== 4'b0000) begin $display("FAIL sat_wstb: got %b expected 0000", ch_wstb); n_fail++; end
    repeat (6) step();
    idle();
    $display("sat: miss_cnt=%h after 65540 write misses", miss_cnt);
    n_checks++;
    if (miss_cnt !== 16'hFFFF) begin $display("FAIL sat_hold: got %h expected FFFF", miss_cnt); n_fail++; end
  endtask

  initial begin
    idle();
    test_reset();
    test_write();
    test_read_hit();
    test_read_miss();
    test_back_to_back();
    test_simul();
    test_reset_mid_read();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
